axi_4_req_sequencer: RTL
========================

// Module: axi_4_req_sequencer
// PURPOSE
//  Upstream front-end of axi_4_master: buffers VLSU load/store requests in an in-order FIFO.
//  Issues them to the master one at a time as ld_req/st_req pulses, with burst fields held stable.
//  Waits for the master's completion strobe, then returns a response (read data for loads) over a valid/ready port.
//  Exactly one AXI transaction is outstanding at any time.
// PARAMETERS
//  DEPTH          4    request FIFO entries (power of 2, >=2)
//  XLEN           32   address width
//  DATA_W         64   AXI data bus width
//  BURST_MAX      8    max beats per burst; payload width = DATA_W*BURST_MAX
//  STRB_W         8    DATA_W/8, strobe bits per beat
//  TIMEOUT_CYCLES 256  watchdog limit (used only with AXI4_REQ_TIMEOUT_EN)
// PORTS
//  clk               in   1                clock, all logic on rising edge
//  reset             in   1                synchronous, active-high
//  req_valid         in   1                VLSU request valid
//  req_ready         out  1                FIFO can accept (= !full)
//  req_is_store      in   1                1=store, 0=load
//  req_addr          in   XLEN             burst base address
//  req_wdata         in   DATA_W*BURST_MAX store payload, beat0 in LSBs
//  req_strobe        in   STRB_W*BURST_MAX store byte strobes
//  req_len           in   8                AXI beats-1
//  req_size          in   3                log2 bytes per beat
//  req_type          in   2                FIXED/INCR/WRAP
//  ld_req, st_req    out  1                one-cycle issue pulse to master
//  base_addr         out  XLEN             to master; FIFO head, stable from ISSUE through RESP
//  vlsu_wdata        out  DATA_W*BURST_MAX to master; FIFO head, stable from ISSUE through RESP
//  write_strobe      out  STRB_W*BURST_MAX to master; FIFO head, stable from ISSUE through RESP
//  burst_len         out  8                to master; FIFO head, stable from ISSUE through RESP
//  burst_size        out  3                to master; FIFO head, stable from ISSUE through RESP
//  burst_type        out  2                to master; FIFO head, stable from ISSUE through RESP
//  burst_valid_data  in   1                master: load burst complete, burst_rdata valid
//  burst_rdata       in   DATA_W*BURST_MAX master read data
//  burst_wr_valid    in   1                master: store response received
//  rsp_valid         out  1                response valid
//  rsp_ready         in   1                consumer accepts response
//  rsp_is_store      out  1                type of completed request
//  rsp_rdata         out  DATA_W*BURST_MAX captured load data (0 for stores)
//  rsp_err           out  1                timeout flag (tied 0 without AXI4_REQ_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: FIFO emptied, FSM->IDLE, every output 0 except req_ready=1; in-flight transaction abandoned.
//  - Enqueue on req_valid&&req_ready. req_len > BURST_MAX-1 is clamped to BURST_MAX-1 at enqueue.
//  - Full: req_ready=0 even if a pop occurs the same cycle; no bypass. Pointers are log2(DEPTH) bits, wrap naturally.
//  - FSM IDLE: FIFO non-empty -> ISSUE next cycle. First possible ISSUE is 2 cycles after accept.
//  - FSM ISSUE (1 cycle): ld_req=1 (load) or st_req=1 (store); ->WAIT.
//  - FSM WAIT: a load leaves on burst_valid_data; a store leaves on burst_wr_valid.
//    On completion: rsp_rdata<=burst_rdata (load) or 0 (store); rsp_is_store<=head type; ->RESP.
//  - Mismatched or out-of-WAIT completion strobes are ignored.
//  - FSM RESP: rsp_valid=1, response fields held; on rsp_ready -> pop head, ->IDLE.
//  - Per-request turnaround, min 3 cycles + master latency; strict in-order completion.
//  - Burst outputs are driven from the FIFO head and are 0 when the FIFO is empty.
//  - Reset has priority over every event; reset mid-WAIT drops the request without a response.
// CONFIGURATION
//  AXI4_REQ_TIMEOUT_EN defined:
//   - 16-bit watchdog counter cleared on ISSUE, incremented in WAIT.
//   - Reaching TIMEOUT_CYCLES without completion -> RESP with rsp_err=1, rsp_rdata=0.
//   - A late completion strobe afterwards is ignored.
//  Undefined: no counter; WAIT waits forever; rsp_err tied 0.
// TESTING
//  1 Store addr=0x100, len=3, size=3, INCR, wdata=CAFEBABE_0000000{1..8}
//     -> st_req pulse exactly 1 cycle, fields stable; after burst_wr_valid, rsp_valid with rsp_is_store=1, rsp_err=0.
//  2 Load addr=0x100, len=3 after scenario 1 -> ld_req pulse; rsp_rdata beats 0..3 = CAFEBABE_00000008..05 (memory readback).
//  3 Push 4 requests back-to-back (DEPTH=4) -> req_ready=0 after 4th.
//     5th held until first response accepted; responses in push order.
//  4 Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stable, no new ld_req/st_req, FIFO count unchanged.
//  5 Enqueue load with len=20 -> burst_len=7. Assert reset during WAIT -> all outputs 0 next cycle, req_ready=1, no response.
//  6 [AXI4_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16] load with master completion suppressed
//     -> rsp_valid with rsp_err=1 after 16 WAIT cycles; next request then proceeds normally.

Source files
------------

// File: rtl/axi_4_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axi_4_req_sequencer
// Brief    : In-order VLSU request FIFO feeding axi_4_master one burst at a
//            time, returning a response (load data) over valid/ready.
//            Optional watchdog enabled by defining AXI4_REQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_4_req_sequencer #(
  parameter int DEPTH          = 4,
  parameter int XLEN           = 32,
  parameter int DATA_W         = 64,
  parameter int BURST_MAX      = 8,
  parameter int STRB_W         = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_is_store,
  input  logic [XLEN-1:0]             req_addr,
  input  logic [DATA_W*BURST_MAX-1:0] req_wdata,
  input  logic [STRB_W*BURST_MAX-1:0] req_strobe,
  input  logic [7:0]                  req_len,
  input  logic [2:0]                  req_size,
  input  logic [1:0]                  req_type,
  output logic                        ld_req,
  output logic                        st_req,
  output logic [XLEN-1:0]             base_addr,
  output logic [DATA_W*BURST_MAX-1:0] vlsu_wdata,
  output logic [STRB_W*BURST_MAX-1:0] write_strobe,
  output logic [7:0]                  burst_len,
  output logic [2:0]                  burst_size,
  output logic [1:0]                  burst_type,
  input  logic                        burst_valid_data,
  input  logic [DATA_W*BURST_MAX-1:0] burst_rdata,
  input  logic                        burst_wr_valid,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_is_store,
  output logic [DATA_W*BURST_MAX-1:0] rsp_rdata,
  output logic                        rsp_err
);
  localparam int            c_pw      = $clog2(DEPTH);
  localparam int            c_pay_w   = DATA_W * BURST_MAX;
  localparam int            c_stb_w   = STRB_W * BURST_MAX;
  localparam logic [c_pw:0] c_full    = (c_pw + 1)'(DEPTH);
  localparam logic [7:0]    c_len_max = 8'(BURST_MAX - 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;
  localparam logic [1:0] c_resp  = 2'd3;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (STRB_W * 8 != DATA_W) ||
      (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_param_check
    $error("axi_4_req_sequencer: illegal parameter set");
  end

  logic               r_is_store [DEPTH];
  logic [XLEN-1:0]    r_addr     [DEPTH];
  logic [c_pay_w-1:0] r_wdata    [DEPTH];
  logic [c_stb_w-1:0] r_strobe   [DEPTH];
  logic [7:0]         r_len      [DEPTH];
  logic [2:0]         r_size     [DEPTH];
  logic [1:0]         r_type     [DEPTH];

  logic [c_pw-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_pw:0]      r_count;
  logic [1:0]         r_state, w_next;
  logic               r_rsp_is_store;
  logic [c_pay_w-1:0] r_rsp_rdata;

  logic w_full, w_empty, w_push, w_pop, w_head_store, w_done, w_timeout, w_finish;

  assign w_full       = (r_count == c_full);
  assign w_empty      = (r_count == '0);
  assign req_ready    = !w_full;
  assign w_push       = req_valid && !w_full;
  assign w_pop        = (r_state == c_resp) && rsp_ready;
  assign w_head_store = r_is_store[r_rd_ptr];
  assign w_done       = (r_state == c_wait) &&
                        (w_head_store ? burst_wr_valid : burst_valid_data);
  assign w_finish     = w_done || w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Payload storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_is_store[r_wr_ptr] <= req_is_store;
      r_addr[r_wr_ptr]     <= req_addr;
      r_wdata[r_wr_ptr]    <= req_wdata;
      r_strobe[r_wr_ptr]   <= req_strobe;
      r_len[r_wr_ptr]      <= (req_len > c_len_max) ? c_len_max : req_len;
      r_size[r_wr_ptr]     <= req_size;
      r_type[r_wr_ptr]     <= req_type;
    end
  end

  assign base_addr    = w_empty ? '0 : r_addr[r_rd_ptr];
  assign vlsu_wdata   = w_empty ? '0 : r_wdata[r_rd_ptr];
  assign write_strobe = w_empty ? '0 : r_strobe[r_rd_ptr];
  assign burst_len    = w_empty ? '0 : r_len[r_rd_ptr];
  assign burst_size   = w_empty ? '0 : r_size[r_rd_ptr];
  assign burst_type   = w_empty ? '0 : r_type[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (!w_empty) w_next = c_issue;
      c_issue: w_next = c_wait;
      c_wait:  if (w_finish) w_next = c_resp;
      c_resp:  if (rsp_ready) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    ld_req    = 1'b0;
    st_req    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      c_issue: begin
        ld_req = !w_head_store;
        st_req = w_head_store;
      end
      c_resp:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_is_store <= 1'b0;
      r_rsp_rdata    <= '0;
    end else if ((r_state == c_wait) && w_finish) begin
      r_rsp_is_store <= w_head_store;
      r_rsp_rdata    <= (w_done && !w_head_store) ? burst_rdata : '0;
    end
  end

  assign rsp_is_store = r_rsp_is_store;
  assign rsp_rdata    = r_rsp_rdata;

`ifdef AXI4_REQ_TIMEOUT_EN
  localparam logic [15:0] c_wd_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wd_cnt;
  logic        r_rsp_err;

  // Counter reads 0 on the first WAIT cycle, so the limit hits on WAIT cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (reset)                     r_wd_cnt <= '0;
    else if (r_state == c_issue)   r_wd_cnt <= '0;
    else if (r_state == c_wait)    r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  assign w_timeout = (r_state == c_wait) && (r_wd_cnt == c_wd_last);

  always_ff @(posedge clk) begin
    if (reset)                                r_rsp_err <= 1'b0;
    else if ((r_state == c_wait) && w_finish) r_rsp_err <= !w_done;
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire
